// File: rtl/chunked_adder_seq_pkg.sv
// Shared types and helpers for the slice-serial adder.
package chunked_adder_seq_pkg;

    // Controller states: waiting, adding one slice per clock, result just produced.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice counter width; a single-slice adder still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/chunked_adder_seq_if.sv
// Start/done handshake and operand/result bus between sequencer and adder.
interface chunked_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             overflow_out;

    // Sequencer side: issues requests, observes results.
    modport master (
        output start_in, a_in, b_in, c_in,
        input  busy_out, done_out, sum_out, c_out, overflow_out
    );

    // Adder side: accepts requests, produces results.
    modport slave (
        input  start_in, a_in, b_in, c_in,
        output busy_out, done_out, sum_out, c_out, overflow_out
    );
endinterface

// File: rtl/chunked_adder_seq_adder_slice.sv
// Combinational SLICE-bit adder built from per-bit carry-group cells.
// Also exposes the carry into the slice's top bit for signed-overflow detection.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_c,
    output logic [SLICE-1:0] o_sum,
    output logic             o_c,
    output logic             o_c_top
);
    logic [SLICE:0]   w_c;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_g;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < SLICE; i++) begin : g_cell
        // Propagate/generate pair for this bit, then the carry it hands upward.
        assign w_p[i]   = i_a[i] ^ i_b[i];
        assign w_g[i]   = i_a[i] & i_b[i];
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        assign o_sum[i] = w_p[i] ^ w_c[i];
    end

    assign o_c     = w_c[SLICE];
    assign o_c_top = w_c[SLICE-1];
endmodule

// File: rtl/chunked_adder_seq.sv
// Slice-serial adder: one SLICE-bit slice per clock, LSB slice first,
// carry held in a register between slices. Results are held until the
// next operation completes.
module chunked_adder_seq
    import chunked_adder_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                clk_in,
    input logic                rst_n_in,
    chunked_adder_seq_if.slave bus
);
    localparam int N  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int CW = cnt_width(N);

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("chunked_adder_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [WIDTH-1:0] w_res_next;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_sum;
    logic             w_c_out;
    logic             w_c_top;
    logic             w_last;
    logic             w_load;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_ov;

    assign w_last = (r_cnt == CW'(N - 1));
    assign w_load = (r_state != ST_RUN) && bus.start_in;

    // Pick the operand slice addressed by the counter.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_sl = r_a[k*SLICE +: SLICE];
                w_b_sl = r_b[k*SLICE +: SLICE];
            end else begin
                w_a_sl = w_a_sl;
                w_b_sl = w_b_sl;
            end
        end
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a     (w_a_sl),
        .i_b     (w_b_sl),
        .i_c     (r_carry),
        .o_sum   (w_sum),
        .o_c     (w_c_out),
        .o_c_top (w_c_top)
    );

    // Merge this cycle's slice sum into the result word at the counter position.
    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_res_next[k*SLICE +: SLICE] = w_sum;
            end else begin
                w_res_next[k*SLICE +: SLICE] = r_res[k*SLICE +: SLICE];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_in) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start_in) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Work registers: capture operands on start, then advance one slice per clock.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_carry <= bus.c_in;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_res   <= w_res_next;
            r_carry <= w_c_out;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Output registers: results load only when the final slice completes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_ov   <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
            if ((r_state == ST_RUN) && w_last) begin
                r_sum <= w_res_next;
                r_c   <= w_c_out;
                r_ov  <= w_c_top ^ w_c_out;
            end
        end
    end

    assign bus.busy_out     = r_busy;
    assign bus.done_out     = r_done;
    assign bus.sum_out      = r_sum;
    assign bus.c_out        = r_c;
    assign bus.overflow_out = r_ov;
endmodule
